// File: rtl/nonce_search_ctrl.sv
// Nonce search job controller: walks an inclusive (possibly wrapping) nonce range,
// issues one SHA-256d request per nonce and stops on the first hash below target.
module nonce_search_ctrl #(
  parameter int unsigned NONCEWIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  go,
  input  logic                  abort,
  input  logic [NONCEWIDTH-1:0] nonce_start,
  input  logic [NONCEWIDTH-1:0] nonce_end,
  input  logic [NONCEWIDTH-1:0] target,
  output logic                  sha_start,
  output logic [NONCEWIDTH-1:0] sha_nonce,
  input  logic                  sha_done,
  input  logic [NONCEWIDTH-1:0] sha_hash_msw,
  output logic                  busy,
  output logic                  complete,
  output logic                  found,
  output logic [NONCEWIDTH-1:0] found_nonce,
  output logic [NONCEWIDTH-1:0] hash_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CHECK
  } state_e;

  state_e                  state_q, state_d;
  logic [NONCEWIDTH-1:0]   nonce_q, nonce_d;
  logic [NONCEWIDTH-1:0]   end_q, end_d;
  logic [NONCEWIDTH-1:0]   target_q, target_d;
  logic [NONCEWIDTH-1:0]   hash_q, hash_d;
  logic [NONCEWIDTH-1:0]   found_nonce_q, found_nonce_d;
  logic [NONCEWIDTH-1:0]   count_q, count_d;
  logic                    complete_q, complete_d;
  logic                    found_q, found_d;
  logic                    start_q, start_d;
  logic                    busy_q, busy_d;

  logic hit;
  logic last;

  assign hit  = (hash_q < target_q);
  assign last = (nonce_q == end_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      nonce_q       <= '0;
      end_q         <= '0;
      target_q      <= '0;
      hash_q        <= '0;
      found_nonce_q <= '0;
      count_q       <= '0;
      complete_q    <= 1'b0;
      found_q       <= 1'b0;
      start_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      nonce_q       <= nonce_d;
      end_q         <= end_d;
      target_q      <= target_d;
      hash_q        <= hash_d;
      found_nonce_q <= found_nonce_d;
      count_q       <= count_d;
      complete_q    <= complete_d;
      found_q       <= found_d;
      start_q       <= start_d;
      busy_q        <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (go) state_d = S_ISSUE;
      S_ISSUE: state_d = abort ? S_IDLE : S_WAIT;
      S_WAIT: begin
        if (abort)         state_d = S_IDLE;
        else if (sha_done) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (abort || hit || last) state_d = S_IDLE;
        else                      state_d = S_ISSUE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Abort overrides the CHECK outcome entirely, including the hash count update.
  always_comb begin
    nonce_d       = nonce_q;
    end_d         = end_q;
    target_d      = target_q;
    hash_d        = hash_q;
    found_nonce_d = found_nonce_q;
    count_d       = count_q;
    complete_d    = complete_q;
    found_d       = found_q;

    if (state_q == S_IDLE) begin
      if (go) begin
        nonce_d       = nonce_start;
        end_d         = nonce_end;
        target_d      = target;
        complete_d    = 1'b0;
        found_d       = 1'b0;
        found_nonce_d = '0;
        count_d       = '0;
      end
    end else if (abort) begin
      complete_d = 1'b1;
      found_d    = 1'b0;
    end else if (state_q == S_WAIT) begin
      if (sha_done) hash_d = sha_hash_msw;
    end else if (state_q == S_CHECK) begin
      count_d = (count_q == '1) ? count_q : count_q + NONCEWIDTH'(1);
      if (hit) begin
        found_d       = 1'b1;
        found_nonce_d = nonce_q;
        complete_d    = 1'b1;
      end else if (last) begin
        complete_d = 1'b1;
        found_d    = 1'b0;
      end else begin
        nonce_d = nonce_q + NONCEWIDTH'(1);
      end
    end

    start_d = (state_d == S_ISSUE);
    busy_d  = (state_d != S_IDLE);
  end

  assign sha_start   = start_q;
  assign sha_nonce   = nonce_q;
  assign busy        = busy_q;
  assign complete    = complete_q;
  assign found       = found_q;
  assign found_nonce = found_nonce_q;
  assign hash_count  = count_q;

endmodule

// File: tb/tb_nonce_search_ctrl.sv
// Bench for nonce_search_ctrl: a latency-L core model plus a range-walk reference
// that predicts the nonce sequence, result and hash count of every job.
module tb_nonce_search_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        go, abort;
  logic [31:0] nonce_start, nonce_end, target;
  logic        sha_start;
  logic [31:0] sha_nonce;
  logic        sha_done;
  logic [31:0] sha_hash_msw;
  logic        busy, complete, found;
  logic [31:0] found_nonce, hash_count;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Core hash behaviour for the current job
  int unsigned hmode;  // 0: mixed, 1: constant, 2: single special nonce
  logic [31:0] hconst, hspecial_n, hspecial_v, hseed;

  nonce_search_ctrl #(.NONCEWIDTH(32)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .go          (go),
    .abort       (abort),
    .nonce_start (nonce_start),
    .nonce_end   (nonce_end),
    .target      (target),
    .sha_start   (sha_start),
    .sha_nonce   (sha_nonce),
    .sha_done    (sha_done),
    .sha_hash_msw(sha_hash_msw),
    .busy        (busy),
    .complete    (complete),
    .found       (found),
    .found_nonce (found_nonce),
    .hash_count  (hash_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] hashfn(input logic [31:0] n);
    logic [31:0] h;
    if (hmode == 1) return hconst;
    if (hmode == 2) return (n == hspecial_n) ? hspecial_v : 32'hFFFF_FFFF;
    h = (n ^ hseed) * 32'h9E37_79B1;
    return h ^ (h >> 15);
  endfunction

  task automatic run_job(input logic [31:0] s, input logic [31:0] e, input logic [31:0] t,
                         input int unsigned lat, input int unsigned abort_k, input bit noise);
    logic [31:0] exp_n[$];
    logic [31:0] n, exp_fn, cur, exp_cnt;
    bit          exp_found, ended;
    int unsigned idx, cyc, last, dones;
    int          cnt;

    n = s; exp_found = 1'b0; exp_fn = '0;
    for (int i = 0; i < 4096; i++) begin
      exp_n.push_back(n);
      if (hashfn(n) < t) begin
        exp_found = 1'b1;
        exp_fn    = n;
        break;
      end
      if (n == e) break;
      n = n + 32'd1;
    end
    if (abort_k != 0) begin
      while (exp_n.size() > abort_k) exp_n.delete(exp_n.size() - 1);
      exp_found = 1'b0;
      exp_cnt   = abort_k - 1;
    end else begin
      exp_cnt = exp_n.size();
    end

    @(negedge clk);
    nonce_start = s; nonce_end = e; target = t; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    idx = 0; cyc = 0; last = 0; dones = 0; cnt = -1; ended = 1'b0; cur = '0;
    while (cyc < 4000) begin
      go = 1'b0; sha_done = 1'b0; abort = 1'b0;
      if (!busy) begin
        ended = 1'b1;
        break;
      end
      if (cnt > 0) cnt--;
      if (cnt == 0) begin
        sha_done     = 1'b1;
        sha_hash_msw = hashfn(cur);
        dones++;
        if (abort_k != 0 && dones == abort_k) abort = 1'b1;
        cnt = -1;
      end
      if (sha_start) begin
        if (idx == 0) check_eq("first_issue_cycle", cyc, 32'd0);
        else          check_eq("issue_interval", cyc - last, lat + 2);
        if (idx < exp_n.size()) check_eq("sha_nonce", sha_nonce, exp_n[idx]);
        else                    check_eq("issue_overrun", idx, exp_n.size() - 1);
        cur  = sha_nonce;
        last = cyc;
        idx++;
        cnt  = int'(lat);
      end
      if (noise) begin
        nonce_start = $urandom;
        nonce_end   = $urandom;
        target      = $urandom;
        go          = ($urandom_range(0, 3) == 0);
      end
      @(negedge clk);
      cyc++;
    end
    go = 1'b0; sha_done = 1'b0; abort = 1'b0;
    check_eq("job_terminated", ended, 1);
    check_eq("issue_count", idx, exp_n.size());
    check_eq("complete", complete, 1);
    check_eq("found", found, exp_found);
    if (exp_found) check_eq("found_nonce", found_nonce, exp_fn);
    check_eq("hash_count", hash_count, exp_cnt);
  endtask

  initial begin
    int unsigned extra;
    logic [31:0] s, len, t, fn_before, cnt_before;
    bit          fnd_before;

    reset_n = 1'b0; go = 1'b0; abort = 1'b0; sha_done = 1'b0;
    nonce_start = '0; nonce_end = '0; target = '0; sha_hash_msw = '0;
    hmode = 0; hconst = '0; hspecial_n = '0; hspecial_v = '0; hseed = '0;
    #12;
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_complete", complete, 0);
    check_eq("rst_found", found, 0);
    check_eq("rst_found_nonce", found_nonce, 0);
    check_eq("rst_hash_count", hash_count, 0);
    check_eq("rst_sha_start", sha_start, 0);
    check_eq("rst_sha_nonce", sha_nonce, 0);

    // Exhausted range, no hit
    hmode = 1; hconst = 32'hFFFF_FFFF;
    run_job(32'h10, 32'h13, 32'h0, 3, 0, 1'b0);

    // Hit on 0x105, then no further requests
    hmode = 2; hspecial_n = 32'h105; hspecial_v = 32'h0000_0FFF;
    run_job(32'h100, 32'h1FF, 32'h0000_1000, 2, 0, 1'b0);
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (sha_start) extra++;
    end
    check_eq("no_issue_after_found", extra, 0);

    // Range wrapping through all-ones
    hmode = 1; hconst = 32'hFFFF_FFFF;
    run_job(32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_1000, 1, 0, 1'b0);

    // Single nonce, hash equal to target is not a hit
    hmode = 1; hconst = 32'h1234;
    run_job(32'h55, 32'h55, 32'h1234, 4, 0, 1'b0);

    // Abort coinciding with a qualifying done, with ignored go pulses mid-job
    hmode = 2; hspecial_n = 32'h22; hspecial_v = 32'h10;
    run_job(32'h20, 32'h30, 32'h100, 2, 3, 1'b1);

    // Stray done in IDLE changes nothing
    fnd_before = found; fn_before = found_nonce; cnt_before = hash_count;
    @(negedge clk);
    sha_done = 1'b1; sha_hash_msw = 32'h0;
    @(negedge clk);
    sha_done = 1'b0;
    @(negedge clk);
    check_eq("stray_busy", busy, 0);
    check_eq("stray_sha_start", sha_start, 0);
    check_eq("stray_complete", complete, 1);
    check_eq("stray_found", found, fnd_before);
    check_eq("stray_found_nonce", found_nonce, fn_before);
    check_eq("stray_hash_count", hash_count, cnt_before);

    // Asynchronous reset while waiting on the core
    hmode = 1; hconst = 32'hFFFF_FFFF;
    @(negedge clk);
    nonce_start = 32'h40; nonce_end = 32'h50; target = 32'h0; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("pre_rst_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_sha_start", sha_start, 0);
    check_eq("arst_sha_nonce", sha_nonce, 0);
    check_eq("arst_complete", complete, 0);
    check_eq("arst_found", found, 0);
    check_eq("arst_hash_count", hash_count, 0);
    @(negedge clk);
    reset_n = 1'b1;
    run_job(32'h40, 32'h42, 32'h0, 2, 0, 1'b0);

    // Randomized jobs with mid-job CSR churn
    for (int j = 0; j < 24; j++) begin
      hmode = 0; hseed = $urandom;
      s   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 5)) : $urandom;
      len = 32'($urandom_range(0, 10));
      t   = 32'($urandom_range(0, 32'h1000_0000));
      run_job(s, s + len, t, $urandom_range(1, 4), 0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
